// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: access size and FSM state.
package dmem_arbiter_pkg;
   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_ILL  = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;
endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store enable/replication and load extraction/extension.
module dmem_lane_align
   import dmem_arbiter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  size_e            size_i,
   input  logic [1:0]       offset_i,
   input  logic             we_i,
   input  logic             unsigned_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [WIDTH-1:0] rdata_i,
   output logic [3:0]       byteen_o,
   output logic [WIDTH-1:0] wdata_o,
   output logic [WIDTH-1:0] rdata_o
);
   logic [WIDTH-1:0] shifted;

   assign shifted = rdata_i >> {offset_i, 3'b000};

   always_comb begin
      byteen_o = 4'b1111;
      wdata_o  = wdata_i;
      rdata_o  = shifted;
      case (size_i)
         SZ_BYTE: begin
            if (we_i) byteen_o = 4'b0001 << offset_i;
            wdata_o = {(WIDTH/8){wdata_i[7:0]}};
            rdata_o = {{(WIDTH-8){shifted[7] & ~unsigned_i}}, shifted[7:0]};
         end
         SZ_HALF: begin
            if (we_i) byteen_o = 4'b0011 << offset_i;
            wdata_o = {(WIDTH/16){wdata_i[15:0]}};
            rdata_o = {{(WIDTH-16){shifted[15] & ~unsigned_i}}, shifted[15:0]};
         end
         SZ_WORD: ;
         default: byteen_o = 4'b0000;
      endcase
   end
endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int MEM_WORDS = 1024
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [1:0]           req_valid,
   output logic [1:0]           req_ready,
   input  logic [1:0]           req_we,
   input  logic [2*WIDTH-1:0]   req_addr,
   input  logic [2*WIDTH-1:0]   req_wdata,
   input  logic [3:0]           req_size,
   input  logic [1:0]           req_unsigned,
   output logic [1:0]           resp_valid,
   output logic [WIDTH-1:0]     resp_rdata,
   output logic                 resp_err,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic [WIDTH-3:0]     mem_addr,
   output logic [WIDTH-1:0]     mem_wdata,
   output logic [3:0]           mem_byteen,
   input  logic [WIDTH-1:0]     mem_rdata
);
   localparam logic [WIDTH-1:0] ADDR_LIMIT = WIDTH'(4 * MEM_WORDS);

   state_e           state_q, state_d;
   logic             last_q, last_d;
   logic             gnt_q, we_q, uns_q, err_q;
   size_e            size_q;
   logic [WIDTH-1:0] addr_q, wdata_q, rdata_q;

   logic             sel, accept, sel_we, sel_uns, sel_err, act;
   logic [1:0]       sel_size;
   logic [WIDTH-1:0] sel_addr, sel_wdata, lane_wdata, lane_rdata;
   logic [3:0]       lane_byteen;

   // Tie goes to whoever was not granted last.
   always_comb begin
      sel = 1'b0;
      case (req_valid)
         2'b10:   sel = 1'b1;
         2'b11:   sel = ~last_q;
         default: sel = 1'b0;
      endcase
   end

   assign accept    = (state_q == IDLE) && rst_n && (req_valid != 2'b00);
   assign req_ready = accept ? (sel ? 2'b10 : 2'b01) : 2'b00;

   assign sel_addr  = sel ? req_addr[2*WIDTH-1:WIDTH]  : req_addr[WIDTH-1:0];
   assign sel_wdata = sel ? req_wdata[2*WIDTH-1:WIDTH] : req_wdata[WIDTH-1:0];
   assign sel_size  = sel ? req_size[3:2] : req_size[1:0];
   assign sel_we    = req_we[sel];
   assign sel_uns   = req_unsigned[sel];

   always_comb begin
      sel_err = (sel_addr >= ADDR_LIMIT);
      case (size_e'(sel_size))
         SZ_HALF: if (sel_addr[0]) sel_err = 1'b1;
         SZ_WORD: if (sel_addr[1:0] != 2'b00) sel_err = 1'b1;
         SZ_ILL:  sel_err = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         IDLE: if (accept) begin
            state_d = ACCESS;
            last_d  = sel;
         end
         ACCESS:  state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   // Request fields are captured only on accept, so later input changes are ignored.
   always_ff @(posedge clk) begin
      if (accept) begin
         gnt_q   <= sel;
         we_q    <= sel_we;
         uns_q   <= sel_uns;
         err_q   <= sel_err;
         size_q  <= size_e'(sel_size);
         addr_q  <= sel_addr;
         wdata_q <= sel_wdata;
      end
      if (state_q == ACCESS) rdata_q <= (err_q || we_q) ? '0 : lane_rdata;
   end

   dmem_lane_align #(.WIDTH(WIDTH)) u_lane_align (
      .size_i     (size_q),
      .offset_i   (addr_q[1:0]),
      .we_i       (we_q),
      .unsigned_i (uns_q),
      .wdata_i    (wdata_q),
      .rdata_i    (mem_rdata),
      .byteen_o   (lane_byteen),
      .wdata_o    (lane_wdata),
      .rdata_o    (lane_rdata)
   );

   assign act        = (state_q == ACCESS) && !err_q;
   assign mem_read   = act && !we_q;
   assign mem_write  = act && we_q;
   assign mem_addr   = act ? addr_q[WIDTH-1:2] : '0;
   assign mem_wdata  = (act && we_q) ? lane_wdata : '0;
   assign mem_byteen = act ? lane_byteen : 4'b0000;

   assign resp_valid = (state_q == RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
   assign resp_err   = (state_q == RESP) && err_q;
   assign resp_rdata = (state_q == RESP) ? rdata_q : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-enabled memory behind it.
module tb_dmem_arbiter;
   logic        clk, rst_n;
   logic [1:0]  req_valid, req_ready, req_we, req_unsigned, resp_valid;
   logic [63:0] req_addr, req_wdata;
   logic [3:0]  req_size, mem_byteen;
   logic [31:0] resp_rdata, mem_wdata, mem_rdata;
   logic        resp_err, mem_read, mem_write;
   logic [29:0] mem_addr;

   logic [31:0] mem [0:1023];
   int n_cmp, n_fail;

   logic        ob_rd, ob_wr, ob_err;
   logic [1:0]  ob_rv1, ob_rv;
   logic [29:0] ob_addr;
   logic [3:0]  ob_be;
   logic [31:0] ob_wd, ob_rdata;

   dmem_arbiter #(.WIDTH(32), .MEM_WORDS(1024)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
      .req_unsigned(req_unsigned), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_byteen(mem_byteen), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[9:0]];
   always @(posedge clk)
      if (mem_write)
         for (int b = 0; b < 4; b++)
            if (mem_byteen[b]) mem[mem_addr[9:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];

   initial begin
      #500000;
      $display("FAIL watchdog expired got running want finished");
      $fatal(1);
   end

   task automatic set_req(input int r, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [1:0] sz, input logic uns);
      req_we[r] = we;
      req_addr[r*32 +: 32] = addr;
      req_wdata[r*32 +: 32] = wd;
      req_size[r*2 +: 2] = sz;
      req_unsigned[r] = uns;
   endtask

   task automatic apply_reset;
      req_valid = 2'b00;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Runs one transaction, scrambling the requester's fields right after accept.
   task automatic drive_txn(input int r, input logic we, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [1:0] sz, input logic uns);
      int waited;
      set_req(r, we, addr, wd, sz, uns);
      req_valid[r] = 1'b1;
      waited = 0;
      @(negedge clk);
      while (req_ready[r] !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      n_cmp++;
      if (req_ready[r] !== 1'b1) begin
         n_fail++;
         $display("FAIL accept_timeout req=%0d got ready=%b want bit %0d set", r, req_ready, r);
      end
      @(posedge clk);
      #1;
      req_valid[r] = 1'b0;
      set_req(r, ~we, 32'hFFFF_FFFF, 32'h0, 2'd3, ~uns);
      @(negedge clk);
      ob_rd = mem_read; ob_wr = mem_write; ob_addr = mem_addr;
      ob_be = mem_byteen; ob_wd = mem_wdata; ob_rv1 = resp_valid;
      @(posedge clk);
      @(negedge clk);
      ob_rv = resp_valid; ob_rdata = resp_rdata; ob_err = resp_err;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      req_valid = 2'b11;
      @(negedge clk);
      n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_ready got %b want 00", req_ready); end
      n_cmp++; if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL rst_resp_valid got %b want 00", resp_valid); end
      n_cmp++; if ({resp_err, resp_rdata} !== 33'h0) begin n_fail++; $display("FAIL rst_resp got err=%b rdata=%h want 0/0", resp_err, resp_rdata); end
      n_cmp++; if ({mem_read, mem_write, mem_byteen, mem_addr, mem_wdata} !== 68'h0) begin n_fail++;
         $display("FAIL rst_mem got rd=%b wr=%b be=%b addr=%h wd=%h want all 0", mem_read, mem_write, mem_byteen, mem_addr, mem_wdata); end
      apply_reset;
   endtask

   task automatic test_word;
      drive_txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 2'd2, 1'b0);
      n_cmp++; if ({ob_wr, ob_rd} !== 2'b10) begin n_fail++; $display("FAIL sw_strobe got wr=%b rd=%b want 1/0", ob_wr, ob_rd); end
      n_cmp++; if (ob_be !== 4'b1111 || ob_addr !== 30'd4) begin n_fail++; $display("FAIL sw_lane got be=%b addr=%h want 1111/4", ob_be, ob_addr); end
      n_cmp++; if (ob_wd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_wdata got %h want deadbeef", ob_wd); end
      n_cmp++; if (ob_rv1 !== 2'b00 || ob_rv !== 2'b01) begin n_fail++; $display("FAIL sw_resp_timing got n1=%b n2=%b want 00/01", ob_rv1, ob_rv); end
      n_cmp++; if (ob_err !== 1'b0 || ob_rdata !== 32'h0) begin n_fail++; $display("FAIL sw_resp got err=%b rdata=%h want 0/0", ob_err, ob_rdata); end
      drive_txn(0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
      n_cmp++; if ({ob_rd, ob_wr} !== 2'b10 || ob_be !== 4'b1111 || ob_addr !== 30'd4) begin n_fail++;
         $display("FAIL lw_mem got rd=%b wr=%b be=%b addr=%h want 1/0/1111/4", ob_rd, ob_wr, ob_be, ob_addr); end
      n_cmp++; if (ob_rv !== 2'b01 || ob_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_rdata got rv=%b rdata=%h want 01/deadbeef", ob_rv, ob_rdata); end
   endtask

   task automatic test_sub_word;
      drive_txn(0, 1'b1, 32'h13, 32'h0000_0080, 2'd0, 1'b0);
      n_cmp++; if (ob_be !== 4'b1000 || ob_wd !== 32'h8080_8080) begin n_fail++; $display("FAIL sb_lane got be=%b wd=%h want 1000/80808080", ob_be, ob_wd); end
      drive_txn(0, 1'b0, 32'h13, 32'h0, 2'd0, 1'b0);
      n_cmp++; if (ob_rdata !== 32'hFFFF_FF80 || ob_be !== 4'b1111) begin n_fail++; $display("FAIL lb_sign got rdata=%h be=%b want ffffff80/1111", ob_rdata, ob_be); end
      drive_txn(0, 1'b0, 32'h13, 32'h0, 2'd0, 1'b1);
      n_cmp++; if (ob_rdata !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_zero got %h want 00000080", ob_rdata); end
      drive_txn(0, 1'b0, 32'h12, 32'h0, 2'd1, 1'b0);
      n_cmp++; if (ob_rdata !== 32'hFFFF_80AD) begin n_fail++; $display("FAIL lh_sign got %h want ffff80ad", ob_rdata); end
      drive_txn(0, 1'b0, 32'h12, 32'h0, 2'd1, 1'b1);
      n_cmp++; if (ob_rdata !== 32'h0000_80AD) begin n_fail++; $display("FAIL lhu_zero got %h want 000080ad", ob_rdata); end
      drive_txn(0, 1'b0, 32'h10, 32'h0, 2'd0, 1'b0);
      n_cmp++; if (ob_rdata !== 32'hFFFF_FFEF) begin n_fail++; $display("FAIL lb_lane0 got %h want ffffffef", ob_rdata); end
      drive_txn(1, 1'b1, 32'h16, 32'h1234_BEEF, 2'd1, 1'b0);
      n_cmp++; if (ob_be !== 4'b1100 || ob_wd !== 32'hBEEF_BEEF || ob_rv !== 2'b10) begin n_fail++;
         $display("FAIL sh_lane got be=%b wd=%h rv=%b want 1100/beefbeef/10", ob_be, ob_wd, ob_rv); end
      drive_txn(1, 1'b0, 32'h14, 32'h0, 2'd2, 1'b0);
      n_cmp++; if (ob_rdata !== 32'hBEEF_0000) begin n_fail++; $display("FAIL lw_after_sh got %h want beef0000", ob_rdata); end
   endtask

   task automatic test_errors;
      drive_txn(0, 1'b0, 32'h11, 32'h0, 2'd1, 1'b0);
      n_cmp++; if ({ob_rd, ob_wr} !== 2'b00 || ob_be !== 4'b0000) begin n_fail++; $display("FAIL lh_mis_strobe got rd=%b wr=%b be=%b want 0/0/0000", ob_rd, ob_wr, ob_be); end
      n_cmp++; if (ob_rv !== 2'b01 || ob_err !== 1'b1 || ob_rdata !== 32'h0) begin n_fail++;
         $display("FAIL lh_mis_resp got rv=%b err=%b rdata=%h want 01/1/0", ob_rv, ob_err, ob_rdata); end
      drive_txn(0, 1'b0, 32'h1000, 32'h0, 2'd2, 1'b0);
      n_cmp++; if (ob_err !== 1'b1 || ob_rd !== 1'b0) begin n_fail++; $display("FAIL lw_range got err=%b rd=%b want 1/0", ob_err, ob_rd); end
      drive_txn(1, 1'b1, 32'h1000, 32'h55, 2'd2, 1'b0);
      n_cmp++; if (ob_err !== 1'b1 || ob_wr !== 1'b0 || ob_rv !== 2'b10) begin n_fail++; $display("FAIL sw_range got err=%b wr=%b rv=%b want 1/0/10", ob_err, ob_wr, ob_rv); end
      drive_txn(0, 1'b0, 32'h12, 32'h0, 2'd2, 1'b0);
      n_cmp++; if (ob_err !== 1'b1) begin n_fail++; $display("FAIL lw_mis got err=%b want 1", ob_err); end
      drive_txn(0, 1'b0, 32'h10, 32'h0, 2'd3, 1'b0);
      n_cmp++; if (ob_err !== 1'b1 || ob_rd !== 1'b0) begin n_fail++; $display("FAIL size3 got err=%b rd=%b want 1/0", ob_err, ob_rd); end
      drive_txn(1, 1'b1, 32'hFFC, 32'hCAFE_F00D, 2'd2, 1'b0);
      n_cmp++; if (ob_err !== 1'b0 || ob_wr !== 1'b1 || ob_addr !== 30'h3FF) begin n_fail++;
         $display("FAIL sw_top got err=%b wr=%b addr=%h want 0/1/3ff", ob_err, ob_wr, ob_addr); end
      drive_txn(1, 1'b0, 32'hFFC, 32'h0, 2'd2, 1'b0);
      n_cmp++; if (ob_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL lw_top got %h want cafef00d", ob_rdata); end
   endtask

   task automatic test_round_robin;
      int grants[4];
      int gcyc[4];
      int n, cyc;
      apply_reset;
      set_req(0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
      set_req(1, 1'b0, 32'hFFC, 32'h0, 2'd2, 1'b0);
      req_valid = 2'b11;
      n = 0;
      cyc = 0;
      while (n < 4 && cyc < 60) begin
         @(negedge clk);
         n_cmp++; if (req_ready === 2'b11) begin n_fail++; $display("FAIL rr_onehot got %b want at most one bit", req_ready); end
         if (req_ready !== 2'b00) begin
            grants[n] = req_ready[1] ? 1 : 0;
            gcyc[n] = cyc;
            n++;
         end
         cyc++;
      end
      req_valid = 2'b00;
      n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL rr_count got %0d want 4", n); end
      for (int i = 0; i < n; i++) begin
         n_cmp++; if (grants[i] !== (i % 2)) begin n_fail++; $display("FAIL rr_grant%0d got %0d want %0d", i, grants[i], i % 2); end
      end
      for (int i = 1; i < n; i++) begin
         n_cmp++; if (gcyc[i] - gcyc[i-1] !== 3) begin n_fail++; $display("FAIL rr_spacing%0d got %0d want 3", i, gcyc[i] - gcyc[i-1]); end
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset_abort;
      logic saw_resp;
      set_req(0, 1'b1, 32'h20, 32'h1234_5678, 2'd2, 1'b0);
      req_valid[0] = 1'b1;
      @(negedge clk);
      n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL abort_accept got %b want 01", req_ready); end
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      n_cmp++; if (mem_write !== 1'b1) begin n_fail++; $display("FAIL abort_in_access got wr=%b want 1", mem_write); end
      #1 rst_n = 1'b0;
      #1;
      n_cmp++; if ({mem_read, mem_write, mem_byteen, mem_addr, mem_wdata} !== 68'h0) begin n_fail++;
         $display("FAIL abort_mem got rd=%b wr=%b be=%b addr=%h wd=%h want all 0", mem_read, mem_write, mem_byteen, mem_addr, mem_wdata); end
      saw_resp = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (resp_valid !== 2'b00) saw_resp = 1'b1;
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (resp_valid !== 2'b00) saw_resp = 1'b1;
      end
      n_cmp++; if (saw_resp !== 1'b0) begin n_fail++; $display("FAIL abort_no_resp got resp seen want none"); end
      n_cmp++; if ({resp_err, resp_rdata, mem_read, mem_write, mem_byteen} !== 39'h0) begin n_fail++;
         $display("FAIL abort_idle_out got err=%b rdata=%h rd=%b wr=%b be=%b want all 0", resp_err, resp_rdata, mem_read, mem_write, mem_byteen); end
      n_cmp++; if (mem[8] !== 32'h0) begin n_fail++; $display("FAIL abort_no_store got %h want 00000000", mem[8]); end
      drive_txn(0, 1'b0, 32'h20, 32'h0, 2'd2, 1'b0);
      n_cmp++; if (ob_rd !== 1'b1 || ob_rv !== 2'b01 || ob_rdata !== 32'h0) begin n_fail++;
         $display("FAIL abort_after got rd=%b rv=%b rdata=%h want 1/01/0", ob_rd, ob_rv, ob_rdata); end
   endtask

   initial begin
      n_cmp = 0;
      n_fail = 0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      req_valid = 2'b00;
      req_we = 2'b00;
      req_addr = '0;
      req_wdata = '0;
      req_size = '0;
      req_unsigned = 2'b00;
      test_reset;
      test_word;
      test_sub_word;
      test_errors;
      test_round_robin;
      test_reset_abort;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, data/address width.
REQ-002 Parameter: MEM_WORDS, 1024, data-memory depth in words (4 KB).
REQ-003 clk  input  1  rising-edge system clock; the block has one clock.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  [1:0]  per-requester request valid; index 0 = core LSU, 1 = DMA/debug loader.
REQ-006 req_ready  output  [1:0]  per-requester accept; request is transferred when valid && ready.
REQ-007 req_we  input  [1:0]  1 = store, 0 = load.
REQ-008 req_addr  input  2 x WIDTH  byte address.
REQ-009 req_wdata  input  2 x WIDTH  store data, right-aligned.
REQ-010 req_size  input  2 x 2  0 = byte, 1 = half, 2 = word; 3 = illegal.
REQ-011 req_unsigned  input  [1:0]  1 = zero-extend loads (lbu/lhu).
REQ-012 resp_valid  output  [1:0]  one-cycle response pulse to the granted requester.
REQ-013 resp_rdata  output  WIDTH  extended load data; 0 for stores and errors.
REQ-014 resp_err  output  1  misaligned, illegal-size or out-of-range access; qualified by resp_valid.
REQ-015 mem_read, mem_write  output  1 each  data-memory strobes.
REQ-016 mem_addr  output  WIDTH-2  word address (byte address >> 2).
REQ-017 mem_wdata  output  WIDTH  lane-replicated store data.
REQ-018 mem_byteen  output  4  byte-lane enable.
REQ-019 mem_rdata  input  WIDTH  combinational read word from memory.

Function
REQ-020 FSM states: IDLE, ACCESS, RESP; IDLE->ACCESS on accept; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
REQ-021 req_ready nonzero only in IDLE; at most one bit set; accepted request fields latched on accept edge.
REQ-022 Arbitration: single valid requester wins; both valid -> requester not granted last (round-robin); last_grant updates on accept only.
REQ-023 Latency: accept at cycle N, mem strobe at N+1, resp_valid at N+2; back-to-back accept earliest N+3.
REQ-024 mem_read/mem_write high only in ACCESS, only for error-free requests; mutually exclusive.
REQ-025 Misaligned: half with addr[0]=1, word with addr[1:0]!=0 -> error.
REQ-026 Out-of-range: addr >= 4*MEM_WORDS -> error; size 3 -> error.
REQ-027 Errored request: no memory strobe, passes through ACCESS, resp_err=1, resp_rdata=0 at N+2.
REQ-028 Store lanes: byte -> byteen 0001<<addr[1:0], wdata {4{b}}; half -> 0011<<addr[1:0], wdata {2{h}}; word -> 1111.
REQ-029 Load: read word captured in ACCESS, shifted right 8*addr[1:0], sign- or zero-extended per req_unsigned; mem_byteen=1111 on loads.
REQ-030 Outside ACCESS all mem_* outputs are 0.
REQ-031 Changes to req_* of a non-granted or already-accepted requester do not affect the transaction in flight.

Reset
REQ-032 rst_n low: state IDLE, last_grant=1 (core wins first tie), req_ready=0 for the reset cycle, resp_valid=0, resp_err=0, resp_rdata=0, mem_* = 0.
REQ-033 Reset mid-ACCESS/RESP aborts the transaction: no response; a store not yet sampled by the memory is not performed.

Structure
REQ-034 Shared package holds the size encoding (BYTE/HALF/WORD) and the FSM state enum.
REQ-035 One combinational sub-module dmem_lane_align performs the store byteen/wdata replication and load extraction.

Verification
REQ-036 Core sw 0xDEADBEEF @0x10, then lw @0x10 -> byteen 1111, mem_addr 4, rdata 0xDEADBEEF at N+2.
REQ-037 sb 0x80 @0x13, then lb @0x13 -> byteen 1000, rdata 0xFFFFFF80; lbu -> 0x00000080.
REQ-038 lh @0x11 -> no mem strobe, resp_err=1, rdata 0; lw @0x1000 -> resp_err=1.
REQ-039 Both requesters valid continuously for 4 transactions -> grants 0,1,0,1 after reset.
REQ-040 rst_n low during ACCESS of sw @0x20 -> no resp_valid; after reset, state IDLE and outputs 0.
